seven_twenty_sign_extend: RTL and testbench
===========================================

Name: seven_twenty_sign_extend

Overview:
- Registered two's-complement sign extender: widens an IN_W-bit signed operand to OUT_W bits, replicating the MSB into every upper bit.
- Default configuration is 7 → 20 bits, feeding 20-bit immediate/address datapaths from a 7-bit instruction field.
- One-cycle latency, valid-qualified, single clock domain.

Parameters:
- IN_W, 7, input operand width; legal range 1 ≤ IN_W ≤ OUT_W.
- OUT_W, 20, output width; elaboration error if OUT_W < IN_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand on a is valid this cycle.
- a  input  IN_W  signed operand.
- out_valid  output  1  extended_a holds a new result.
- extended_a  output  OUT_W  sign-extended result.
- is_negative  output  1  registered copy of a[IN_W-1] for the captured operand.

Behaviour:
- All outputs are registered and update only on rising clk.
- Reset (reset=1 at clock edge): extended_a=0, out_valid=0, is_negative=0.
- Reset has priority over in_valid when both are high.
- Capture (in_valid=1, reset=0), visible next cycle (latency exactly 1):
  - extended_a[IN_W-1:0] = a.
  - extended_a[OUT_W-1:IN_W] = {OUT_W-IN_W{a[IN_W-1]}}.
  - is_negative = a[IN_W-1].
  - out_valid = 1.
- Idle (in_valid=0): out_valid=0 next cycle; extended_a and is_negative hold their last captured values.
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- Boundary cases:
  - IN_W == OUT_W: pure registered pass-through.
  - a = most-negative value (MSB only): upper bits all ones.
  - a = all ones: result all ones (−1).
  - a = 0: result 0 and is_negative=0.
- Deasserting reset mid-stream: the first capture happens on the first edge with reset=0 and in_valid=1.
- No X propagation: with in_valid=0, a is ignored.

Optional Feature:
- Macro SEXT_ZERO_MODE_EN.
- When defined:
  - Extra input zext_mode (1 bit, sampled together with a on in_valid).
  - zext_mode=1: upper bits are filled with 0, and is_negative is forced to 0.
  - zext_mode=0: behaviour is identical to the base block.
- When undefined: the port does not exist and the block always sign-extends.

Decomposition:
- Package sext_pkg:
  - Default width constants SEXT_IN_W=7 and SEXT_OUT_W=20.
  - Typedefs sext_in_t and sext_out_t.
  - Pure function sign_extend(in).
- One natural combinational sub-module, sign_ext_core: replicates the MSB (optionally zero-fills); holds no state.
- Top level adds the valid register, output registers and reset logic.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, a=7'h7F → extended_a=20'h00000, out_valid=0, is_negative=0 throughout reset.
- Directed values, back-to-back with in_valid=1; each result appears 1 cycle after its input:
  - 7'b0000001 → 20'h00001, neg=0.
  - 7'b1000000 → 20'hFFFC0, neg=1.
  - 7'b1111111 → 20'hFFFFF, neg=1.
  - 7'b0011111 → 20'h0001F, neg=0.
  - 7'b1010101 → 20'hFFFD5, neg=1.
- Hold: capture 7'b1010101, then in_valid=0 for 3 cycles while a toggles → extended_a stays 20'hFFFD5 and out_valid=0 after the first cycle.
- Reset mid-stream: reset=1 together with in_valid=1, a=7'h40 → next cycle outputs 0; on release, the first valid 7'h01 yields 20'h00001.
- SEXT_ZERO_MODE_EN build: a=7'b1000000 with zext_mode=1 → 20'h00040, neg=0; same a with zext_mode=0 → 20'hFFFC0.
- Exhaustive: all 128 values of a compared against the reference function sign_extend, out_valid asserted for each result.

Source files
------------

// File: rtl/sext_pkg.sv
// rtl/sext_pkg.sv - shared widths, types and reference function for the sign extender
//
// Purpose : default operand/result widths, the matching vector types and a
//           pure sign_extend() function usable as a golden reference.
// Contents: SEXT_IN_W, SEXT_OUT_W, sext_in_t, sext_out_t, sign_extend().
package sext_pkg;

  localparam int SEXT_IN_W  = 7;
  localparam int SEXT_OUT_W = 20;

  typedef logic [SEXT_IN_W-1:0]  sext_in_t;
  typedef logic [SEXT_OUT_W-1:0] sext_out_t;

  function automatic sext_out_t sign_extend(input sext_in_t inVal);
    return {{(SEXT_OUT_W-SEXT_IN_W){inVal[SEXT_IN_W-1]}}, inVal};
  endfunction

endpackage

// File: rtl/sign_ext_core.sv
// rtl/sign_ext_core.sv - combinational MSB replication / zero fill
//
// Purpose : widens an IN_W-bit operand to OUT_W bits by replicating its MSB,
//           or by filling with zeros when zeroFill is set. Holds no state.
// Ports   : a        in  IN_W   operand
//           zeroFill in  1      fill upper bits with 0 instead of the MSB
//           extended out OUT_W  widened operand
//           negative out 1      sign of the widened value (0 when zero-filling)
module sign_ext_core
  import sext_pkg::*;
#(
  parameter int IN_W  = SEXT_IN_W,
  parameter int OUT_W = SEXT_OUT_W
) (
  input  logic [IN_W-1:0]  a,
  input  logic             zeroFill,
  output logic [OUT_W-1:0] extended,
  output logic             negative
);

  logic fillBit;

  assign fillBit  = zeroFill ? 1'b0 : a[IN_W-1];
  // The fill bit is exactly the sign of the widened result in both modes.
  assign negative = fillBit;

  if (OUT_W > IN_W) begin : gExtend
    assign extended = {{(OUT_W-IN_W){fillBit}}, a};
  end else begin : gPass
    // Equal widths: nothing to fill, straight pass-through.
    assign extended = a;
  end

endmodule

// File: rtl/seven_twenty_sign_extend.sv
// rtl/seven_twenty_sign_extend.sv - registered, valid-qualified sign extender (7 -> 20 by default)
//
// Purpose : captures a when in_valid is high and presents its sign-extended
//           form one cycle later. Results hold while idle; out_valid pulses
//           once per captured operand.
// Ports   : clk         in  1      rising-edge clock
//           reset       in  1      synchronous active-high reset (beats in_valid)
//           in_valid    in  1      a (and zext_mode) valid this cycle
//           zext_mode   in  1      only with SEXT_ZERO_MODE_EN: zero-extend instead
//           a           in  IN_W   signed operand
//           out_valid   out 1      extended_a holds a new result
//           extended_a  out OUT_W  widened result
//           is_negative out 1      sign of the captured result
// Config  : define SEXT_ZERO_MODE_EN to add the zext_mode input.
module seven_twenty_sign_extend
  import sext_pkg::*;
#(
  parameter int IN_W  = SEXT_IN_W,
  parameter int OUT_W = SEXT_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
`ifdef SEXT_ZERO_MODE_EN
  input  logic             zext_mode,
`endif
  input  logic [IN_W-1:0]  a,
  output logic             out_valid,
  output logic [OUT_W-1:0] extended_a,
  output logic             is_negative
);

  if (IN_W < 1 || OUT_W < IN_W) begin : gBadWidth
    $error("seven_twenty_sign_extend: need 1 <= IN_W <= OUT_W");
  end

  logic             zeroFill;
  logic [OUT_W-1:0] coreExtended;
  logic             coreNegative;

`ifdef SEXT_ZERO_MODE_EN
  assign zeroFill = zext_mode;
`else
  assign zeroFill = 1'b0;
`endif

  sign_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) uCore (
    .a        (a),
    .zeroFill (zeroFill),
    .extended (coreExtended),
    .negative (coreNegative)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      extended_a  <= '0;
      is_negative <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Data registers only load on a valid operand, so a is don't-care when idle.
      if (in_valid) begin
        extended_a  <= coreExtended;
        is_negative <= coreNegative;
      end
    end
  end

endmodule

// File: tb/tb_seven_twenty_sign_extend.sv
// tb/tb_seven_twenty_sign_extend.sv - directed self-checking bench for seven_twenty_sign_extend
module tb_seven_twenty_sign_extend;
  import sext_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [6:0]  a;
  logic        out_valid;
  logic [19:0] extended_a;
  logic        is_negative;
`ifdef SEXT_ZERO_MODE_EN
  logic        zext_mode = 1'b0;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [6:0]  vecA   [5] = '{7'b0000001, 7'b1000000, 7'b1111111, 7'b0011111, 7'b1010101};
  logic [19:0] vecExt [5] = '{20'h00001, 20'hFFFC0, 20'hFFFFF, 20'h0001F, 20'hFFFD5};
  logic        vecNeg [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [6:0]  holdA  [3] = '{7'h2A, 7'h55, 7'h00};

  always #5 clk = ~clk;

  seven_twenty_sign_extend dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
`ifdef SEXT_ZERO_MODE_EN
    .zext_mode   (zext_mode),
`endif
    .a           (a),
    .out_valid   (out_valid),
    .extended_a  (extended_a),
    .is_negative (is_negative)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag, input logic [19:0] ext, input logic vld, input logic neg);
    chk({tag, "_ext"}, {12'h0, extended_a}, {12'h0, ext});
    chk({tag, "_vld"}, {31'h0, out_valid}, {31'h0, vld});
    chk({tag, "_neg"}, {31'h0, is_negative}, {31'h0, neg});
  endtask

  initial begin
    // Reset held two cycles with a valid operand present: reset must win.
    reset = 1'b1; in_valid = 1'b1; a = 7'h7F;
    tick();
    chkAll("reset1", 20'h00000, 1'b0, 1'b0);
    tick();
    chkAll("reset2", 20'h00000, 1'b0, 1'b0);

    // Back-to-back directed operands; each result is checked after the edge that captured it.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = vecA[i];
      tick();
      chkAll($sformatf("vec%0d", i), vecExt[i], 1'b1, vecNeg[i]);
    end

    // Hold: data keeps the last capture while a wiggles with in_valid low.
    a = 7'b1010101;
    tick();
    chkAll("holdCap", 20'hFFFD5, 1'b1, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = holdA[i];
      tick();
      chkAll($sformatf("hold%0d", i), 20'hFFFD5, 1'b0, 1'b1);
    end

    // Reset mid-stream, then the first valid operand after release.
    reset = 1'b1; in_valid = 1'b1; a = 7'h40;
    tick();
    chkAll("midReset", 20'h00000, 1'b0, 1'b0);
    reset = 1'b0; a = 7'h01;
    tick();
    chkAll("postReset", 20'h00001, 1'b1, 1'b0);

    // Zero input.
    a = 7'h00;
    tick();
    chkAll("zero", 20'h00000, 1'b1, 1'b0);

`ifdef SEXT_ZERO_MODE_EN
    a = 7'b1000000; zext_mode = 1'b1;
    tick();
    chkAll("zext1", 20'h00040, 1'b1, 1'b0);
    zext_mode = 1'b0;
    tick();
    chkAll("zext0", 20'hFFFC0, 1'b1, 1'b1);
`endif

    // Exhaustive sweep against the package reference function.
    for (int v = 0; v < 128; v++) begin
      a = 7'(v);
      tick();
      chkAll($sformatf("sweep%0d", v), sign_extend(7'(v)), 1'b1, a[6]);
    end

    in_valid = 1'b0;
    tick();
    chk("finalIdle", {31'h0, out_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
